shift_rows_pipe: RTL
====================

# shift_rows_pipe

Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage with valid/ready flow control. It supports block widths of 128, 192 and 256 bits (Nb = 4, 6, 8) and selects forward or inverse per transaction. Pipeline depth is configurable. It sits between SubBytes and MixColumns in the round datapath, and between InvSubBytes and AddRoundKey in the decrypt datapath.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8. Data width W = 32*NB.
- STAGES, default 1: register stages, 1..4. Any other NB or STAGES value is an elaboration error.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a block.
- in_ready  output  1  block accepted on this edge when in_valid && in_ready.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
- in_data  input  [0:W-1]  state, column-major; byte k = bits [8k:8k+7], row r = k mod 4, column c = k div 4.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_inv  output  1  mode bit that travelled with the block.
- out_data  output  [0:W-1]  transformed state, same byte layout.

## Operation
- Row shift amounts: NB = 4 or 6 gives 0, 1, 2, 3; NB = 8 gives 0, 1, 3, 4.
- Forward: out s(r,c) = in s(r, (c + shift[r]) mod NB).
- Inverse: out s(r,c) = in s(r, (c − shift[r] + NB) mod NB).
- Permutation is pure wiring, applied combinationally in front of stage 0. Stages 1..STAGES−1 only delay data and the inv bit.
- Each stage i holds data[i], inv[i] and valid[i]. out_* are driven from the last stage.
- Stage advance is bubble-collapsing:
  - Last stage loads when !valid[last] || out_ready.
  - Stage i loads when !valid[i] || stage i+1 loads.
  - Stage 0 load enable is in_ready.
  - When a stage loads, it takes its predecessor's contents. valid[i] becomes the predecessor's valid; for stage 0 that is in_valid.
- in_ready is combinational from out_ready and the valid bits. It does not depend on in_valid.
- Data registers load only when the incoming valid is 1. Stalled stages hold data and inv bit-exactly.
- No state machine beyond per-stage valid bits. No ordering change; blocks exit in acceptance order.

## Timing
- Reset (rst = 0, asynchronous): all valid[i] = 0, all data = 0, all inv = 0. Outputs immediately read out_valid = 0, out_data = 0, out_inv = 0, in_ready = 1.
- Reset asserted mid-operation discards all in-flight blocks; nothing is replayed after release.
- First accepting edge is the first rising clk after rst deasserts.
- Latency: a block accepted on edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. during cycle n+STAGES. This assumes no stall.
- Throughput: one block per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0 and every stage holds.
- Bubbles ahead of a stalled stage are filled: in_ready stays 1 until every stage is valid.
- Simultaneous events: when out_ready = 1 and the pipe is full, a new block is accepted on the same edge as the last one leaves; occupancy is unchanged.
- Mode may change every transaction, with no penalty.

## Test plan
- NB=4, STAGES=1, inv=0: in 63C0AB20EB2F30CB9F93AF2BA092C7A2 → out 632FAFA2EB93C7209F92ABCBA0C0302B, one cycle after acceptance. Second vector: BC3804205138FF26EEEB9A39B31218A1 → BC389AA151EB1820EE120426B338FF39.
- NB=4, inv=1: in 632FAFA2EB93C7209F92ABCBA0C0302B → out 63C0AB20EB2F30CB9F93AF2BA092C7A2, out_inv = 1. Alternate inv 0/1 back-to-back and check each output against the matching mode.
- NB=6 and NB=8, forward, in byte k = k (00 01 … ):
  - NB=6: out first word 00050A0F, last word 1401060B.
  - NB=8: out first word 00050E13, last word 1C010A0F.
  - Inverse of each output returns the counting pattern.
- STAGES=3, continuous in_valid = 1, out_ready held 0 for 5 cycles then 1:
  - in_ready drops after exactly 3 accepts.
  - No block is lost or duplicated; outputs appear in order, one per cycle after release.
  - out_data is stable while stalled.
- STAGES=3, random in_valid/out_ready over 1000 blocks, checked against a reference model: per-block data, inv and order all match.
- Pull rst low with 2 blocks in flight: out_valid = 0 and out_data = 0 with no clock edge. After release, in_ready = 1 and the next block emerges after exactly STAGES cycles.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: Rijndael ShiftRows / InvShiftRows for NB = 4/6/8
// with a bubble-collapsing valid/ready register pipeline.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [0:32*NB-1]  out_data
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end

  logic [0:W-1] fwd;
  logic [0:W-1] bwd;
  logic [0:W-1] perm;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FS = (c + SH) % NB;
      localparam int BS = (c - SH + NB) % NB;
      assign fwd[8*(4*c+r) +: 8] = in_data[8*(4*FS+r) +: 8];
      assign bwd[8*(4*c+r) +: 8] = in_data[8*(4*BS+r) +: 8];
    end
  end

  assign perm = in_inv ? bwd : fwd;

  logic [0:W-1]      data_q [STAGES];
  logic [STAGES-1:0] inv_q;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] load;

  logic [0:W-1]      src_d [STAGES];
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_i;

  assign src_d[0] = perm;
  assign src_v[0] = in_valid;
  assign src_i[0] = in_inv;

  for (genvar i = 1; i < STAGES; i++) begin : g_src
    assign src_d[i] = data_q[i-1];
    assign src_v[i] = vld_q[i-1];
    assign src_i[i] = inv_q[i-1];
  end

  // A stage advances if out_ready or any stage at/after it is empty.
  always_comb begin
    load = '0;
    for (int i = 0; i < STAGES; i++) begin
      load[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld_q[j]) load[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          vld_q[i] <= src_v[i];
          if (src_v[i]) begin
            data_q[i] <= src_d[i];
            inv_q[i]  <= src_i[i];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule
